// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared neuron/layer types: controller state enum and offset width helper
package nn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      MAC,
      BIAS,
      ACT,
      HOLD
   } ctrl_state_t;

   // Width of a pair index for an n-input neuron; never narrower than one bit.
   function automatic int offset_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/neuron_controller_if.sv
// rtl/neuron_controller_if.sv - start/busy, datapath strobe and result handshake bundle
interface neuron_controller_if
   import nn_pkg::*;
#(
   parameter int N  = 10,
   parameter int DW = 8
);
   localparam int OW = offset_w(N);

   logic          start;
   logic          busy;
   logic [OW-1:0] offset;
   logic          ld;
   logic          clr;
   logic          mult_done;
   logic          ready;
   logic [DW-1:0] dp_result;
   logic [DW-1:0] y;
   logic          out_valid;
   logic          out_ack;

   modport master (
      input  start, dp_result, out_ack,
      output busy, offset, ld, clr, mult_done, ready, y, out_valid
   );

   modport slave (
      output start, dp_result, out_ack,
      input  busy, offset, ld, clr, mult_done, ready, y, out_valid
   );

endinterface

// File: rtl/neuron_controller.sv
// rtl/neuron_controller.sv - sequences one neuron datapath: clear, N MACs, bias, activate, hold result
module neuron_controller
   import nn_pkg::*;
#(
   parameter int N  = 10,
   parameter int DW = 8
) (
   input  logic                clk,
   input  logic                rst,
   neuron_controller_if.master bus
);
   localparam int            OW     = offset_w(N);
   localparam logic [OW-1:0] K_LAST = OW'(N - 1);

   ctrl_state_t   state_q, state_d;
   logic [OW-1:0] k_q, k_d;
   logic [DW-1:0] y_q;
   logic          capture;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         if (capture) y_q <= bus.dp_result;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      capture = 1'b0;
      case (state_q)
         IDLE: if (bus.start) state_d = CLR;
         CLR: begin
            state_d = MAC;
            k_d     = '0;
         end
         MAC: begin
            // k parks at zero on exit so offset is already 0 outside MAC
            if (k_q == K_LAST) begin
               state_d = BIAS;
               k_d     = '0;
            end else begin
               k_d = k_q + OW'(1);
            end
         end
         BIAS: state_d = ACT;
         ACT: begin
            state_d = HOLD;
            capture = 1'b1;
         end
         HOLD: if (bus.out_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.clr       = (state_q == CLR);
   assign bus.ld        = (state_q == MAC) || (state_q == BIAS);
   assign bus.mult_done = (state_q == BIAS);
   assign bus.ready     = (state_q == ACT);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.offset    = (state_q == MAC) ? k_q : '0;
   assign bus.y         = y_q;

endmodule

// File: tb/tb_neuron_controller.sv
// tb/tb_neuron_controller.sv - randomized and directed bench for neuron_controller against a cycle-count model
module tb_neuron_controller;
   localparam int N  = 10;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   neuron_controller_if #(.N(N), .DW(DW)) bus ();
   neuron_controller #(.N(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Model: evaluation phase t counts cycles since start was taken (CLR is t=1, HOLD is t>=N+4).
   bit            m_act = 1'b0;
   int            m_t   = 0;
   logic [DW-1:0] m_y   = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_act = 1'b0;
         m_t   = 0;
         m_y   = '0;
      end else if (!m_act) begin
         if (bus.start) begin
            m_act = 1'b1;
            m_t   = 1;
         end
      end else if (m_t == N + 3) begin
         m_y = bus.dp_result;
         m_t = N + 4;
      end else if (m_t >= N + 4) begin
         if (bus.out_ack) m_act = 1'b0;
      end else begin
         m_t++;
      end
   end

   int n_clr = 0, n_ld = 0, n_md = 0, n_rdy = 0, n_val = 0;
   int offs[$];
   int valid_cyc[$];
   bit prev_valid = 1'b0;

   always @(negedge clk) begin
      int e_off;
      e_off = (m_act && m_t >= 2 && m_t <= N + 1) ? m_t - 2 : 0;
      chk("busy",      bus.busy,      m_act);
      chk("clr",       bus.clr,       m_act && m_t == 1);
      chk("ld",        bus.ld,        m_act && m_t >= 2 && m_t <= N + 2);
      chk("mult_done", bus.mult_done, m_act && m_t == N + 2);
      chk("ready",     bus.ready,     m_act && m_t == N + 3);
      chk("out_valid", bus.out_valid, m_act && m_t >= N + 4);
      chk("offset",    bus.offset,    e_off);
      chk("y",         bus.y,         m_y);
      if (bus.clr) n_clr++;
      if (bus.ld) n_ld++;
      if (bus.ld && bus.mult_done) n_md++;
      if (bus.ld && !bus.mult_done) offs.push_back(int'(bus.offset));
      if (bus.ready) n_rdy++;
      if (bus.out_valid) begin
         n_val++;
         if (!prev_valid) valid_cyc.push_back(cyc);
      end
      prev_valid = bus.out_valid;
   end

   int s_cyc = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue();
      int w;
      w = 0;
      while (bus.busy && w < 200) begin
         step();
         w++;
      end
      if (w >= 200) chk("busy_timeout", 1, 0);
      bus.start = 1'b1;
      s_cyc = cyc;
      step();
      bus.start = 1'b0;
   endtask

   task automatic clear_stats();
      n_clr = 0; n_ld = 0; n_md = 0; n_rdy = 0; n_val = 0;
      offs.delete();
      valid_cyc.delete();
   endtask

   initial begin
      int w;
      bus.start     = 1'b0;
      bus.out_ack   = 1'b0;
      bus.dp_result = '0;
      #1 rst = 1'b0;
      #2;
      chk("rst_busy", bus.busy, 0);
      chk("rst_offset", bus.offset, 0);
      chk("rst_y", bus.y, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      step();

      // Sequence, capture, backpressure, ignored start in MAC and HOLD
      clear_stats();
      bus.dp_result = 8'h5A;
      issue();
      for (int i = 1; i <= N + 3; i++) begin
         bus.start = (i == 4);
         step();
      end
      bus.start = 1'b0;
      bus.dp_result = 8'hFF;
      for (int i = 0; i < 20; i++) begin
         bus.start = (i == 10);
         chk("hold_y", bus.y, 8'h5A);
         chk("hold_valid", bus.out_valid, 1);
         step();
      end
      bus.start   = 1'b0;
      bus.out_ack = 1'b1;
      step();
      bus.out_ack = 1'b0;
      chk("busy_after_ack", bus.busy, 0);
      chk("n_clr", n_clr, 1);
      chk("n_ld", n_ld, 11);
      chk("n_mult_done", n_md, 1);
      chk("n_ready", n_rdy, 1);
      chk("n_valid", n_val, 21);
      chk("n_offs", offs.size(), 10);
      for (int i = 0; i < offs.size(); i++) chk("offset_seq", offs[i], i);
      chk("n_valid_rise", valid_cyc.size(), 1);
      if (valid_cyc.size() > 0) chk("latency", valid_cyc[0] - s_cyc, 14);

      // out_ack in IDLE changes nothing
      step();
      bus.out_ack = 1'b1;
      step();
      bus.out_ack = 1'b0;
      step();
      chk("idle_ack_busy", bus.busy, 0);
      chk("idle_ack_valid", bus.out_valid, 0);
      chk("idle_ack_y", bus.y, 8'h5A);

      // Asynchronous reset mid-MAC at offset 5
      issue();
      w = 0;
      while (bus.offset != 5 && w < 30) begin
         step();
         w++;
      end
      chk("reach_offset5", bus.offset, 5);
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_ld", bus.ld, 0);
      chk("arst_clr", bus.clr, 0);
      chk("arst_md", bus.mult_done, 0);
      chk("arst_ready", bus.ready, 0);
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_offset", bus.offset, 0);
      chk("arst_y", bus.y, 0);
      repeat (2) step();
      @(negedge clk) rst = 1'b1;
      step();
      chk("post_rst_busy", bus.busy, 0);

      // Back-to-back with out_ack tied high
      clear_stats();
      bus.out_ack = 1'b1;
      bus.dp_result = 8'h33;
      issue();
      issue();
      repeat (20) step();
      bus.out_ack = 1'b0;
      chk("b2b_rises", valid_cyc.size(), 2);
      chk("b2b_valid_cycles", n_val, 2);
      if (valid_cyc.size() == 2) chk("b2b_spacing", valid_cyc[1] - valid_cyc[0], 15);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         bus.start     = ($urandom_range(3) == 0);
         bus.out_ack   = ($urandom_range(2) == 0);
         bus.dp_result = DW'($urandom);
         step();
      end
      bus.start   = 1'b0;
      bus.out_ack = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
